spi_byte_link: RTL and testbench

SPI-slave front end feeding the control unit's byte command stream.
- Samples SPI mode 0 (CPOL=0, CPHA=0) pins in the clk domain and assembles MSB-first bytes.
- Buffers the bytes in a FIFO and presents the head byte with a valid flag; the control unit's one-cycle `next` pulse pops it.
- Shifts the controller's status byte back out on MISO.

---
 rtl/spi_byte_link_pkg.sv | 11 +
 rtl/spi_byte_link_fifo.sv | 85 ++++++++
 rtl/spi_byte_link.sv | 150 +++++++++++++++
 tb/tb_spi_byte_link.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_byte_link_pkg.sv
// Shared constants for the SPI byte link: default synchroniser depth,
// default receive FIFO depth and the level driven on MISO while deselected.
package spi_byte_link_pkg;

  localparam int SPI_SYNC_STAGES_DEFAULT = 2;
  localparam int SPI_FIFO_DEPTH_DEFAULT  = 16;
  localparam logic SPI_IDLE_MISO         = 1'b0;

  typedef logic [7:0] spi_byte_t;

endpackage

// File: rtl/spi_byte_link_fifo.sv
// Single-clock FIFO with a registered head: dout/valid/count all change on
// the same edge, so a consumer never sees a head byte that disagrees with valid.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               dout,
  output logic                           valid,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;

  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_count_next;
  logic [CW-1:0]    w_remaining;
  logic [WIDTH-1:0] w_dout_next;

  // Popping an empty FIFO is ignored; a full FIFO still accepts a push when it pops in the same cycle.
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_do_pop     = pop && r_valid;
  assign w_do_push    = push && (!w_full || w_do_pop);
  assign w_rd_next    = w_do_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_count_next = r_count + CW'(w_do_push) - CW'(w_do_pop);
  assign w_remaining  = r_count - CW'(w_do_pop);

  // The new head is either an entry already stored or, when nothing else remains, the byte being pushed.
  always_comb begin
    w_dout_next = r_dout;
    if (w_remaining == '0) begin
      if (w_do_push) begin
        w_dout_next = din;
      end
    end else begin
      w_dout_next = r_mem[w_rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_dout   <= w_dout_next;
      r_valid  <= (w_count_next != '0);
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
  assign count = r_count;
  assign full  = w_full;

endmodule

// File: rtl/spi_byte_link.sv
// SPI mode-0 slave front end: oversamples the SPI pins in the clk domain,
// queues received MSB-first bytes and shifts the controller's status byte out.
module spi_byte_link
  import spi_byte_link_pkg::*;
#(
  parameter int FIFO_DEPTH  = SPI_FIFO_DEPTH_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              spi_sck,
  input  logic                              spi_cs_n,
  input  logic                              spi_mosi,
  output logic                              spi_miso,
  input  logic [7:0]                        status_byte,
  output logic [7:0]                        out_byte,
  output logic                              out_valid,
  input  logic                              pop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              overflow
);

  // Handshake to the controller: out_byte is meaningful while out_valid is
  // high; a one-cycle pop with out_valid high consumes it and the next head
  // (or out_valid low) is presented on the following cycle.

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_n_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_sync_live;
  logic                   r_sck_d;
  logic                   r_cs_n_d;
  logic                   r_armed;
  logic [2:0]             r_bit_cnt;
  spi_byte_t              r_rx_shift;
  spi_byte_t              r_tx_shift;
  logic                   r_miso;
  logic                   r_overflow;

  logic      w_sck;
  logic      w_cs_n;
  logic      w_mosi;
  logic      w_rise;
  logic      w_fall;
  logic      w_sel;
  logic      w_cs_fall;
  logic      w_rx_bit;
  logic      w_push;
  spi_byte_t w_rx_byte;
  logic      w_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_cs_n_sync <= '1;
      r_mosi_sync <= '0;
      r_sync_live <= '0;
      r_sck_d     <= 1'b0;
      r_cs_n_d    <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_n_sync <= {r_cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sync_live <= {r_sync_live[SYNC_STAGES-2:0], 1'b1};
      r_sck_d     <= w_sck;
      r_cs_n_d    <= w_cs_n;
    end
  end

  assign w_sck     = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n    = r_cs_n_sync[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sck && !r_sck_d;
  assign w_fall    = !w_sck && r_sck_d;
  assign w_sel     = !w_cs_n;
  assign w_cs_fall = r_cs_n_d && !w_cs_n;

  // The preset cs_n=1 must not count as "seen high"; arming waits until real pin samples fill the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed <= 1'b0;
    end else if (r_sync_live[SYNC_STAGES-1] && w_cs_n) begin
      r_armed <= 1'b1;
    end
  end

  assign w_rx_bit  = w_rise && w_sel && r_armed;
  assign w_rx_byte = {r_rx_shift[6:0], w_mosi};
  assign w_push    = w_rx_bit && (r_bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt  <= 3'd0;
      r_rx_shift <= '0;
    end else if (!w_sel) begin
      r_bit_cnt <= 3'd0;
    end else if (w_rx_bit) begin
      r_rx_shift <= w_rx_byte;
      r_bit_cnt  <= r_bit_cnt + 3'd1;
    end
  end

  // bit_cnt==0 on a fall means a whole byte just completed, so a fresh status byte is loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_shift <= '0;
      r_miso     <= SPI_IDLE_MISO;
    end else if (!w_sel) begin
      r_miso <= SPI_IDLE_MISO;
    end else if (w_cs_fall) begin
      r_tx_shift <= status_byte;
      r_miso     <= status_byte[7];
    end else if (w_fall && r_armed) begin
      if (r_bit_cnt == 3'd0) begin
        r_tx_shift <= status_byte;
        r_miso     <= status_byte[7];
      end else begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        r_miso     <= r_tx_shift[6];
      end
    end
  end

  byte_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .din   (w_rx_byte),
    .pop   (pop),
    .dout  (out_byte),
    .valid (out_valid),
    .count (fifo_count),
    .full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= w_push && w_full && !(pop && out_valid);
    end
  end

  assign spi_miso = r_miso;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_spi_byte_link.sv
// Bench for spi_byte_link: a bit-banged SPI master drives frames, expected
// bytes go into a queue and a monitor pops the DUT FIFO and compares.
module tb_spi_byte_link;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] status_byte;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       pop;
  logic [4:0] fifo_count;
  logic       overflow;

  logic       man_pop;
  logic       mon_pop;
  logic       consume_en;
  logic [7:0] exp_q[$];
  int         n_checks;
  int         n_fail;
  int         ovf_cnt;

  assign pop = man_pop | mon_pop;

  spi_byte_link dut (
    .clk         (clk),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .status_byte (status_byte),
    .out_byte    (out_byte),
    .out_valid   (out_valid),
    .pop         (pop),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: consumes the head when enabled, then idles one cycle before re-sampling.
  always @(negedge clk) begin
    if (mon_pop) begin
      mon_pop = 1'b0;
    end else if (consume_en && out_valid && !reset) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_byte", int'(out_byte), -1);
      end else begin
        check("mon_head", int'(out_byte), int'(exp_q.pop_front()));
      end
      mon_pop = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (overflow) ovf_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic cs_low();
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Sends the top n bits of b; miso_b collects MISO as the master sees it on each rise.
  task automatic send_bits(input logic [7:0] b, input int n, input bit pop_last,
                           input bit chg_en, input logic [7:0] chg_val,
                           output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      miso_b  = {miso_b[6:0], spi_miso};
      if (pop_last && i == n - 1) begin
        repeat (2) @(negedge clk);
        man_pop = 1'b1;
        @(negedge clk);
        man_pop = 1'b0;
        repeat (HALF - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (chg_en && i == 3) status_byte = chg_val;
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] m;
    send_bits(b, 8, 1'b0, 1'b0, 8'h00, m);
  endtask

  task automatic do_pop();
    @(negedge clk);
    man_pop = 1'b1;
    @(negedge clk);
    man_pop = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    consume_en = 1'b1;
    for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid || mon_pop); i++) begin
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    consume_en = 1'b0;
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_count_after"}, int'(fifo_count), 0);
  endtask

  initial begin
    logic [7:0] m1;
    logic [7:0] m2;
    int         ovf0;
    n_checks    = 0;
    n_fail      = 0;
    ovf_cnt     = 0;
    reset       = 1'b1;
    spi_sck     = 1'b0;
    spi_cs_n    = 1'b1;
    spi_mosi    = 1'b0;
    status_byte = 8'h00;
    man_pop     = 1'b0;
    mon_pop     = 1'b0;
    consume_en  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_byte", int'(out_byte), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_miso", int'(spi_miso), 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);

    // single byte
    cs_low();
    exp_q.push_back(8'hA5);
    send_byte(8'hA5);
    cs_high();
    check("t1_count", int'(fifo_count), 1);
    check("t1_valid", int'(out_valid), 1);
    check("t1_head", int'(out_byte), 'hA5);
    wait_drain("t1");

    // three bytes, manual pops
    cs_low();
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i));
    end
    cs_high();
    check("t2_count3", int'(fifo_count), 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_valid", int'(out_valid), 1);
      check("t2_head", int'(out_byte), int'(exp_q.pop_front()));
      do_pop();
    end
    check("t2_empty_valid", int'(out_valid), 0);
    check("t2_empty_count", int'(fifo_count), 0);
    do_pop();
    check("t2_extra_pop_count", int'(fifo_count), 0);
    check("t2_extra_pop_valid", int'(out_valid), 0);

    // fill, then overflow
    cs_low();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h10 + i));
      send_byte(8'(8'h10 + i));
    end
    ovf0 = ovf_cnt;
    send_byte(8'hEE);
    cs_high();
    check("t3_ovf_pulses", ovf_cnt - ovf0, 1);
    check("t3_count_full", int'(fifo_count), 16);
    check("t3_head_kept", int'(out_byte), 'h10);
    wait_drain("t3a");

    // fill, then push with a simultaneous pop
    cs_low();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      send_byte(8'(8'h20 + i));
    end
    check("t3b_head_before_pop", int'(out_byte), int'(exp_q.pop_front()));
    ovf0 = ovf_cnt;
    exp_q.push_back(8'hEE);
    send_bits(8'hEE, 8, 1'b1, 1'b0, 8'h00, m1);
    cs_high();
    check("t3b_no_ovf", ovf_cnt - ovf0, 0);
    check("t3b_count_full", int'(fifo_count), 16);
    wait_drain("t3b");

    // status byte returned on MISO, refreshed per byte
    status_byte = 8'h3C;
    cs_low();
    exp_q.push_back(8'h55);
    send_bits(8'h55, 8, 1'b0, 1'b1, 8'hC3, m1);
    exp_q.push_back(8'h66);
    send_bits(8'h66, 8, 1'b0, 1'b0, 8'h00, m2);
    cs_high();
    check("t4_miso_byte1", int'(m1), 'h3C);
    check("t4_miso_byte2", int'(m2), 'hC3);
    check("t4_miso_idle", int'(spi_miso), 0);
    wait_drain("t4");

    // partial byte discarded on CS rise
    cs_low();
    send_bits(8'hB0, 5, 1'b0, 1'b0, 8'h00, m1);
    cs_high();
    check("t5_partial_no_push", int'(fifo_count), 0);
    cs_low();
    exp_q.push_back(8'h7E);
    send_byte(8'h7E);
    cs_high();
    check("t5_count", int'(fifo_count), 1);
    wait_drain("t5");

    // reset in the middle of a frame
    cs_low();
    send_bits(8'hF0, 4, 1'b0, 1'b0, 8'h00, m1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send_bits(8'h50, 4, 1'b0, 1'b0, 8'h00, m1);
    send_byte(8'h99);
    check("t6_no_push_in_frame", int'(fifo_count), 0);
    cs_high();
    check("t6_no_push_after_cs", int'(fifo_count), 0);
    cs_low();
    exp_q.push_back(8'h42);
    send_byte(8'h42);
    cs_high();
    check("t6_count", int'(fifo_count), 1);
    check("t6_head", int'(out_byte), 'h42);
    wait_drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
